rv32i_mc_ctrl: RTL
==================

# rv32i_mc_ctrl

Multi-cycle control unit for the RV32I core: the producer side of the ALU's `alu_func`/flag interface. It sequences FETCH → DECODE → EXECUTE → WRITEBACK per instruction. It drives the ALU function code and the datapath select and strobe lines, consumes `zero_flag`, `SLT_flag` and `SLTu_flag` for branch resolution, and handshakes with a wait-stated unified memory.

## Interface
- `ALU_FUNC_W`, default 4: ALU function code width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous, active-high. While high, all strobes are 0.
- `opcode` in 7: `IR[6:0]`.
- `funct3` in 3: `IR[14:12]`.
- `funct7_5` in 1: `IR[30]`.
- `zero_flag`, `SLT_flag`, `SLTu_flag` in 1 each: ALU flags.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write access.
- `adr_src` out 1: memory address select; 0=PC, 1=ALUOut.
- `ir_write`, `pc_write`, `reg_write` out 1 each: register-enable strobes.
- `alu_func` out 4: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 xor, 8 slt, 9 sltu.
- `alu_src_a` out 2: 0=PC, 1=oldPC, 2=regA, 3=zero.
- `alu_src_b` out 2: 0=regB, 1=imm, 2=const 4.
- `result_src` out 2: 0=ALUOut, 1=memory data register, 2=ALU result. This is the PC-next and rd bus.
- `illegal_instr` out 1: 1-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- State register holds one of: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, HALT.
- Outputs are combinational from state, `opcode`, `funct3`, `funct7_5`, the flags and `mem_ready`. Every unlisted output is 0 and `alu_func` defaults to add.
- **FETCH**
  - Drives `mem_req=1`, `adr_src=0`, ALU = PC + 4 (`src_a=0`, `src_b=2`), `result_src=2`.
  - `ir_write` and `pc_write` pulse only in the cycle `mem_ready=1`; that cycle moves to DECODE. Otherwise the state holds.
- **DECODE**
  - ALU = oldPC + imm into ALUOut (branch/JAL target).
  - Next state: load/store → MEMADR; R → EXECR; I-ALU → EXECI; branch → BRANCH; JAL → JAL; JALR → JALR; LUI/AUIPC → UPPER.
  - Any other opcode pulses `illegal_instr`.
- **MEMADR**: ALU = regA + imm. Next MEMRD for a load, MEMWR for a store.
- **MEMRD**: `mem_req=1`, `adr_src=1`; waits for `mem_ready`, then MEMWB.
- **MEMWB**: `result_src=1`, `reg_write=1`, then FETCH.
- **MEMWR**: `mem_req=1`, `mem_we=1`, `adr_src=1`; waits for `mem_ready`, then FETCH.
- **EXECR / EXECI** (then ALUWB)
  - EXECR uses regA op regB; EXECI uses regA op imm.
  - `funct3` decode: 000 add, or sub when R and `funct7_5=1`; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when `funct7_5=1` (both R and I); 110 or; 111 and.
- **ALUWB**: `result_src=0`, `reg_write=1`, then FETCH.
- **BRANCH**
  - Computes regA vs regB and sets `pc_write=1`, `result_src=0` when taken. Next FETCH.
  - beq/bne: sub; taken on `zero_flag` / `!zero_flag`.
  - blt/bge: slt; taken on `SLT_flag` / `!SLT_flag`.
  - bltu/bgeu: sltu; taken on `SLTu_flag` / `!SLTu_flag`.
- **JAL**: ALU = oldPC + 4; `result_src=0`, `pc_write=1`. Then ALUWB, which writes the link address.
- **JALR**: ALU = regA + imm into ALUOut, then JAL.
- **UPPER**: `src_a=3` for LUI or `src_a=1` for AUIPC; `src_b=1`; add. Then ALUWB.

## Timing
- With zero wait states:
  - R/I/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
- Each cycle with `mem_ready=0` in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- `rst` sampled high: state becomes FETCH at that edge. While `rst=1`, all strobes and `mem_req` are 0, including mid-access. The first request follows the first edge with `rst=0`.
- `mem_ready` asserted outside a requesting state is ignored.

## Configuration
- `RV32I_MC_CTRL_ILLEGAL_HALT_EN` defined: an illegal opcode enters HALT. HALT keeps all strobes at 0 and is left only by `rst`.
- Macro undefined: an illegal opcode returns to FETCH and executes as a NOP (PC already advanced). HALT is unreachable.

## Structure
- Shared package `rv32i_pkg` holds:
  - ALU function code constants 0–9.
  - Opcode constants.
  - The state enumeration.
  - `alu_src_a`, `alu_src_b` and `result_src` encodings.
- Sub-module `rv32i_alu_dec` (combinational) maps `funct3`/`funct7_5`/R-versus-I to `alu_func`.

## Test plan
- `add` (0x33, f3=000, f7_5=0), `mem_ready` tied 1 → states FETCH, DECODE, EXECR, ALUWB; `alu_func=0` in EXECR; one `reg_write` pulse in cycle 4.
- `sub` (f7_5=1), then `srai` (0x13, f3=101, f7_5=1) → `alu_func=1`, then `alu_func=6`.
- `lw` (0x03) with `mem_ready` low for 2 cycles in MEMRD → 7 total cycles; `result_src=1` and `reg_write` in MEMWB.
- `blt` with `SLT_flag=1` → `alu_func=8`, `pc_write=1` in cycle 3. `bgeu` with `SLTu_flag=1` → `alu_func=9`, `pc_write=0`.
- `jalr` → states DECODE, JALR, JAL, ALUWB; `pc_write` in JAL; `reg_write` in ALUWB.
- Opcode 0x7F → `illegal_instr` pulse. With the macro: HALT until `rst`. Without it: FETCH. `rst` asserted in MEMWR with `mem_ready=0` → `mem_req=0` the same cycle, FETCH after.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU function codes, opcodes, control-FSM states
// and the datapath select encodings driven by the multi-cycle controller.
package rv32i_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, HALT
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REGA  = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/rv32i_alu_dec.sv
// ALU function decoder for R-type and I-type ALU instructions.
module rv32i_alu_dec
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            // srai shares funct7_5 with sra, so the I form honours it too
            3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/WRITEBACK) with a wait-stated memory.
// Define RV32I_MC_CTRL_ILLEGAL_HALT_EN to park in HALT on an illegal opcode.
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int ALU_FUNC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero_flag,
    input  logic                  SLT_flag,
    input  logic                  SLTu_flag,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic                  illegal_instr
);

    state_t     state, state_nxt;
    logic [3:0] dec_func;
    logic [3:0] func;
    logic       br_flag;
    logic       br_taken;

    rv32i_alu_dec u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_rtype (opcode == OP_R),
        .alu_op   (dec_func)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // funct3[0] inverts the sense; the 01x encodings are not branches and never take
    always_comb begin
        br_flag = 1'b0;
        case (funct3[2:1])
            2'b00:   br_flag = zero_flag;
            2'b10:   br_flag = SLT_flag;
            2'b11:   br_flag = SLTu_flag;
            default: br_flag = 1'b0;
        endcase
        br_taken = (funct3[2:1] != 2'b01) && (br_flag ^ funct3[0]);
    end

    always_comb begin
        state_nxt     = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        func          = ALU_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REGB;
        result_src    = RES_ALUOUT;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:              state_nxt = EXECR;
                    OP_I:              state_nxt = EXECI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    OP_JALR:           state_nxt = JALR;
                    OP_LUI, OP_AUIPC:  state_nxt = UPPER;
                    default: begin
                        illegal_instr = 1'b1;
`ifdef RV32I_MC_CTRL_ILLEGAL_HALT_EN
                        state_nxt = HALT;
`else
                        state_nxt = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                state_nxt = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                result_src = RES_MDR;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_nxt = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = (state == EXECI) ? SRCB_IMM : SRCB_REGB;
                func      = dec_func;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                case (funct3[2:1])
                    2'b10:   func = ALU_SLT;
                    2'b11:   func = ALU_SLTU;
                    default: func = ALU_SUB;
                endcase
                pc_write  = br_taken;
                state_nxt = FETCH;
            end
            // ALUOut already holds the jump target; the ALU forms the link address
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_nxt = ALUWB;
            end
            JALR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                state_nxt = JAL;
            end
            UPPER: begin
                alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_nxt = ALUWB;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        // Reset silences every output immediately, even mid-access
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            func          = ALU_ADD;
            alu_src_a     = SRCA_PC;
            alu_src_b     = SRCB_REGB;
            result_src    = RES_ALUOUT;
        end
    end

    assign alu_func = ALU_FUNC_W'(func);

endmodule
